i2s_frame_capture: RTL and testbench

I2S_FRAME_CAPTURE -- requirements
Module: i2s_frame_capture

---
 rtl/i2s_frame_capture.sv | 211 +++++++++++++++++++++
 tb/tb_i2s_frame_capture.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_capture.sv
// I2S frame capture: pairs the left/right samples of each I2S frame on the
// falling edge of word-select and queues them in a show-ahead FIFO of stereo
// frames. Optional drop statistics are enabled by defining I2S_CAPTURE_STATS_EN;
// without it drop_count is tied to zero.
module i2s_frame_capture #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    lrclk,
  input  logic [WIDTH-1:0]        left_chan,
  input  logic [WIDTH-1:0]        right_chan,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [WIDTH-1:0]        frame_left,
  output logic [WIDTH-1:0]        frame_right,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  input  logic                    overflow_clr,
  output logic [15:0]             drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = 2 * WIDTH;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  typedef enum logic [0:0] {
    StSync,
    StRun
  } state_e;

  // Word-select edge detection
  logic lrclk_q;
  logic ws_rise;
  logic ws_fall;

  // Capture FSM
  state_e state_q, state_d;

  // FIFO state
  logic [FW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] head_q, head_d;

  // Handshake / control
  logic [FW-1:0] frame_in;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;

  logic overflow_q, overflow_d;

  assign ws_rise  = ~lrclk_q & lrclk;
  assign ws_fall  = lrclk_q & ~lrclk;
  assign frame_in = {left_chan, right_chan};

  assign full  = (count_q == CountFull);
  assign push  = (state_q == StRun) & ws_fall;
  assign pop   = frame_valid & frame_ready;
  // Full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Word-select history for edge detection
  always_ff @(posedge sclk) begin
    if (rst) begin
      lrclk_q <= 1'b0;
    end else begin
      lrclk_q <= lrclk;
    end
  end

  // FSM state register
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= StSync;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave SYNC on the first word-select rise
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSync: begin
        if (ws_rise) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StSync;
      end
    endcase
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Next head frame; forward the incoming frame when it lands in the head slot
  always_comb begin
    head_d = head_q;
    if (count_d != '0) begin
      if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
        head_d = frame_in;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates their use
  always_ff @(posedge sclk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= frame_in;
    end
  end

  // FIFO control registers and registered head
  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Sticky overflow; a drop in the clear cycle wins
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Overflow flag register
  always_ff @(posedge sclk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

`ifdef I2S_CAPTURE_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; clear restarts the count from this cycle's drop
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_clr) begin
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register
  always_ff @(posedge sclk) begin
    if (rst) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'd0;
`endif

  assign frame_valid = (count_q != '0);
  assign frame_left  = head_q[FW-1:WIDTH];
  assign frame_right = head_q[WIDTH-1:0];
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_i2s_frame_capture.sv
// Directed self-checking bench for i2s_frame_capture (DEPTH=8, WIDTH=16).
module tb_i2s_frame_capture;

  logic        sclk;
  logic        rst;
  logic        lrclk;
  logic [15:0] left_chan;
  logic [15:0] right_chan;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_left;
  logic [15:0] frame_right;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        overflow_clr;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;

`ifdef I2S_CAPTURE_STATS_EN
  localparam logic [15:0] ExpDrop2 = 16'd2;
  localparam logic [15:0] ExpDrop1 = 16'd1;
`else
  localparam logic [15:0] ExpDrop2 = 16'd0;
  localparam logic [15:0] ExpDrop1 = 16'd0;
`endif

  i2s_frame_capture #(
    .DEPTH(8),
    .WIDTH(16)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .lrclk       (lrclk),
    .left_chan   (left_chan),
    .right_chan  (right_chan),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_left  (frame_left),
    .frame_right (frame_right),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .overflow_clr(overflow_clr),
    .drop_count  (drop_count)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // One I2S frame: a rise cycle, then a fall cycle carrying the samples.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    lrclk = 1'b1;
    tick();
    lrclk      = 1'b0;
    left_chan  = l;
    right_chan = r;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lrclk = 1'b1;
    left_chan = 16'h5A5A;
    right_chan = 16'hA5A5;
    frame_ready = 1'b0;
    overflow_clr = 1'b0;
    tick();
    tick();
    checks++;
    if (frame_valid !== 1'b0 || fifo_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_fifo: valid=%b count=%0d want 0 0", frame_valid, fifo_count);
    end
    checks++;
    if (frame_left !== 16'h0 || frame_right !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: got %h/%h want 0000/0000", frame_left, frame_right);
    end
    checks++;
    if (overflow !== 1'b0 || drop_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_ovf: ovf=%b drops=%0d want 0 0", overflow, drop_count);
    end
    lrclk = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (fifo_count !== 4'd0) begin
      failures++;
      $display("FAIL sync_no_capture: count=%0d want 0", fifo_count);
    end
  endtask

  task automatic test_first_frame();
    lrclk = 1'b1;
    tick();
    checks++;
    if (fifo_count !== 4'd0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL rise_no_push: count=%0d valid=%b want 0 0", fifo_count, frame_valid);
    end
    lrclk = 1'b0;
    left_chan = 16'h1234;
    right_chan = 16'hABCD;
    #1;
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass: valid=%b want 0", frame_valid);
    end
    tick();
    checks++;
    if (frame_valid !== 1'b1 || frame_left !== 16'h1234 || frame_right !== 16'hABCD) begin
      failures++;
      $display("FAIL first_frame: valid=%b data=%h/%h want 1 1234/abcd",
               frame_valid, frame_left, frame_right);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    checks++;
    if (frame_valid !== 1'b0 || fifo_count !== 4'd0 || frame_left !== 16'h1234) begin
      failures++;
      $display("FAIL first_pop: valid=%b count=%0d left=%h want 0 0 1234",
               frame_valid, fifo_count, frame_left);
    end
    // Ready with nothing stored must not underflow.
    frame_ready = 1'b1;
    tick();
    checks++;
    if (fifo_count !== 4'd0) begin
      failures++;
      $display("FAIL no_underflow: count=%0d want 0", fifo_count);
    end
  endtask

  task automatic test_push_empty_ready();
    frame_ready = 1'b1;
    send_frame(16'h0F0F, 16'hF0F0);
    checks++;
    if (fifo_count !== 4'd1 || frame_left !== 16'h0F0F) begin
      failures++;
      $display("FAIL push_empty_ready: count=%0d left=%h want 1 0f0f", fifo_count, frame_left);
    end
    tick();
    frame_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd0) begin
      failures++;
      $display("FAIL push_empty_ready_pop: count=%0d want 0", fifo_count);
    end
  endtask

  task automatic test_ordered_pop();
    logic [15:0] exp_l;
    frame_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(16'h1111 * 16'(i + 1), 16'h2000 + 16'(i));
    frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_l = 16'h1111 * 16'(i + 1);
      checks++;
      if (fifo_count !== 4'(4 - i) || frame_left !== exp_l ||
          frame_right !== 16'h2000 + 16'(i)) begin
        failures++;
        $display("FAIL ordered_pop[%0d]: count=%0d data=%h/%h want %0d %h/%h", i, fifo_count,
                 frame_left, frame_right, 4 - i, exp_l, 16'h2000 + 16'(i));
      end
      tick();
    end
    frame_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL ordered_pop_empty: count=%0d valid=%b want 0 0", fifo_count, frame_valid);
    end
  endtask

  task automatic test_overflow();
    frame_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_frame(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1 || drop_count !== ExpDrop2) begin
      failures++;
      $display("FAIL overflow: count=%0d ovf=%b drops=%0d want 8 1 %0d",
               fifo_count, overflow, drop_count, ExpDrop2);
    end
    frame_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (frame_left !== 16'h0100 + 16'(i) || frame_right !== 16'h0200 + 16'(i)) begin
        failures++;
        $display("FAIL overflow_data[%0d]: got %h/%h want %h/%h", i, frame_left, frame_right,
                 16'h0100 + 16'(i), 16'h0200 + 16'(i));
      end
      tick();
    end
    frame_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: count=%0d ovf=%b want 0 1", fifo_count, overflow);
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_count !== 16'h0) begin
      failures++;
      $display("FAIL overflow_clear: ovf=%b drops=%0d want 0 0", overflow, drop_count);
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_l;
    frame_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(16'hA000 + 16'(i), 16'hB000 + 16'(i));
    lrclk = 1'b1;
    tick();
    lrclk = 1'b0;
    left_chan = 16'hBEEF;
    right_chan = 16'hCAFE;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b0 || frame_left !== 16'hA001) begin
      failures++;
      $display("FAIL full_push_pop: count=%0d ovf=%b head=%h want 8 0 a001",
               fifo_count, overflow, frame_left);
    end
    frame_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_l = (i == 7) ? 16'hBEEF : 16'hA001 + 16'(i);
      checks++;
      if (frame_left !== exp_l) begin
        failures++;
        $display("FAIL full_push_pop_data[%0d]: got %h want %h", i, frame_left, exp_l);
      end
      if (i == 7) begin
        checks++;
        if (frame_right !== 16'hCAFE) begin
          failures++;
          $display("FAIL full_push_pop_tail: right=%h want cafe", frame_right);
        end
      end
      tick();
    end
    frame_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd0) begin
      failures++;
      $display("FAIL full_push_pop_empty: count=%0d want 0", fifo_count);
    end
  endtask

  task automatic test_clr_drop();
    frame_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_frame(16'hC000 + 16'(i), 16'hD000 + 16'(i));
    lrclk = 1'b1;
    tick();
    lrclk = 1'b0;
    left_chan = 16'hDEAD;
    right_chan = 16'hDEAD;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || drop_count !== ExpDrop1 || fifo_count !== 4'd8) begin
      failures++;
      $display("FAIL clr_with_drop: ovf=%b drops=%0d count=%0d want 1 %0d 8",
               overflow, drop_count, fifo_count, ExpDrop1);
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_count !== 16'h0 || frame_left !== 16'hC000) begin
      failures++;
      $display("FAIL clr_alone: ovf=%b drops=%0d head=%h want 0 0 c000",
               overflow, drop_count, frame_left);
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(16'hE000 + 16'(i), 16'hF000 + 16'(i));
    checks++;
    if (fifo_count !== 4'd5) begin
      failures++;
      $display("FAIL midstream_fill: count=%0d want 5", fifo_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (frame_valid !== 1'b0 || fifo_count !== 4'd0 || frame_left !== 16'h0) begin
      failures++;
      $display("FAIL midstream_reset: valid=%b count=%0d left=%h want 0 0 0000",
               frame_valid, fifo_count, frame_left);
    end
    lrclk = 1'b0;
    tick();
    tick();
    lrclk = 1'b1;
    tick();
    checks++;
    if (fifo_count !== 4'd0) begin
      failures++;
      $display("FAIL midstream_no_capture: count=%0d want 0", fifo_count);
    end
    lrclk = 1'b0;
    left_chan = 16'h5555;
    right_chan = 16'h6666;
    tick();
    checks++;
    if (fifo_count !== 4'd1 || frame_left !== 16'h5555 || frame_right !== 16'h6666) begin
      failures++;
      $display("FAIL midstream_resume: count=%0d data=%h/%h want 1 5555/6666",
               fifo_count, frame_left, frame_right);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_push_empty_ready();
    test_ordered_pop();
    test_overflow();
    test_full_push_pop();
    test_clr_drop();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
